// File: rtl/hamming_secded_stream_decoder.sv
// Two-stage pipelined Hamming decoder for a valid/ready codeword stream.
// Define HAMMING_SECDED_EN to check the overall parity bit and flag double errors; otherwise pure SEC.
module hamming_secded_stream_decoder #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16,
  // Fixed-point iteration of P = clog2(DATA_W+P+1); three steps converge for DATA_W 1..64
  localparam int P1 = $clog2(DATA_W + 1),
  localparam int P2 = $clog2(DATA_W + P1 + 1),
  localparam int P  = $clog2(DATA_W + P2 + 1),
  localparam int N  = DATA_W + P,
`ifdef HAMMING_SECDED_EN
  localparam int CW_W = N + 1
`else
  localparam int CW_W = N
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CW_W-1:0]   in_cw,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [P-1:0]      out_syndrome,
  output logic              out_corrected,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  // Hamming position (1-based) holding data bit j: the j-th non-power-of-two index.
  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 1; i < 256; i++) begin
      if (((i & (i - 1)) != 0) && (pos == 0)) begin
        if (cnt == j) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [P-1:0]      s1_syn_q, s1_syn_d;
`ifdef HAMMING_SECDED_EN
  logic              s1_pa_q, s1_pa_d;
  logic              in_pa;
`endif
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [P-1:0]      s2_syn_q, s2_syn_d;
  logic              s2_corr_q, s2_corr_d;
  logic              s2_uncorr_q, s2_uncorr_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

  logic              s1_load, s2_load, out_hs;
  logic [P-1:0]      in_syn;
  logic [DATA_W-1:0] raw_data, fix_data;
  logic              flip, is_corr, is_uncorr;

  always_comb begin
    in_syn = '0;
    for (int k = 0; k < P; k++) begin
      for (int i = 1; i <= N; i++) begin
        if (((i >> k) & 1) != 0) in_syn[k] = in_syn[k] ^ in_cw[i-1];
      end
    end
  end

`ifdef HAMMING_SECDED_EN
  assign in_pa = ^in_cw;
`endif

  // S1 keeps only the data positions; parity positions are fully summarised by the syndrome.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
    localparam int POS = data_pos(gi);
    localparam logic [P-1:0] POS_SYN = POS[P-1:0];
    assign raw_data[gi] = in_cw[POS-1];
    assign fix_data[gi] = s1_data_q[gi] ^ (flip && (s1_syn_q == POS_SYN));
  end

  always_comb begin
    flip      = 1'b0;
    is_corr   = 1'b0;
    is_uncorr = 1'b0;
`ifdef HAMMING_SECDED_EN
    if (s1_syn_q == '0) begin
      is_corr = s1_pa_q;
    end else if (!s1_pa_q) begin
      is_uncorr = 1'b1;
    end else if (int'(s1_syn_q) <= N) begin
      flip    = 1'b1;
      is_corr = 1'b1;
    end else begin
      is_uncorr = 1'b1;
    end
`else
    if (s1_syn_q != '0) begin
      if (int'(s1_syn_q) <= N) begin
        flip    = 1'b1;
        is_corr = 1'b1;
      end else begin
        is_uncorr = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    s2_load      = !s2_valid_q || out_ready;
    s1_load      = !s1_valid_q || s2_load;
    out_hs       = s2_valid_q && out_ready;
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_syn_d     = s1_syn_q;
`ifdef HAMMING_SECDED_EN
    s1_pa_d      = s1_pa_q;
`endif
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_syn_d     = s2_syn_q;
    s2_corr_d    = s2_corr_q;
    s2_uncorr_d  = s2_uncorr_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = raw_data;
        s1_syn_d  = in_syn;
`ifdef HAMMING_SECDED_EN
        s1_pa_d   = in_pa;
`endif
      end
    end

    // Payload only moves with a real word, so out_* hold their last value when idle.
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d   = fix_data;
        s2_syn_d    = s1_syn_q;
        s2_corr_d   = is_corr;
        s2_uncorr_d = is_uncorr;
      end
    end

    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_hs) begin
      if (s2_corr_q && (corr_cnt_q != '1))     corr_cnt_d   = corr_cnt_q + CNT_W'(1);
      if (s2_uncorr_q && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
`ifdef HAMMING_SECDED_EN
      s1_pa_q      <= 1'b0;
`endif
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_syn_q     <= '0;
      s2_corr_q    <= 1'b0;
      s2_uncorr_q  <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_syn_q     <= s1_syn_d;
`ifdef HAMMING_SECDED_EN
      s1_pa_q      <= s1_pa_d;
`endif
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_syn_q     <= s2_syn_d;
      s2_corr_q    <= s2_corr_d;
      s2_uncorr_q  <= s2_uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign in_ready      = s1_load;
  assign out_valid     = s2_valid_q;
  assign out_data      = s2_data_q;
  assign out_syndrome  = s2_syn_q;
  assign out_corrected = s2_corr_q;
  assign out_uncorr    = s2_uncorr_q;
  assign corr_cnt      = corr_cnt_q;
  assign uncorr_cnt    = uncorr_cnt_q;

endmodule
